// File: rtl/led_arbiter.sv
// LED ownership arbiter between the HPS and fabric requesters.
// Ownership is held for a minimum number of cycles before the other side
// may preempt; a free-running heartbeat is shown on the LEDs while idle.
module led_arbiter #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned HB_DIV      = 25000000
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       hps_req,
  input  logic [7:0] hps_pattern,
  input  logic       fab_req,
  input  logic [7:0] fab_pattern,
  output logic       hps_gnt,
  output logic       fab_gnt,
  output logic [7:0] leds,
  output logic [3:0] status
);

  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);
  localparam logic [25:0] HB_LAST   = 26'(HB_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HPS_OWN = 2'd1,
    FAB_OWN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic        last_fab_q, last_fab_d;
  logic [25:0] hb_cnt_q;
  logic        hb_q;
  logic [7:0]  leds_q, leds_d;
  logic        pending;

  // State, hold counter and last-owner registers
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      last_fab_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      last_fab_q <= last_fab_d;
    end
  end

  // Next-state: preemption at hold expiry takes priority over release
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    last_fab_d = last_fab_q;
    case (state_q)
      IDLE: begin
        if (hps_req && fab_req) state_d = last_fab_q ? HPS_OWN : FAB_OWN;
        else if (hps_req)       state_d = HPS_OWN;
        else if (fab_req)       state_d = FAB_OWN;
      end
      HPS_OWN: begin
        if (hold_q == '0 && fab_req) state_d = FAB_OWN;
        else if (!hps_req)           state_d = IDLE;
        else if (hold_q != '0)       hold_d  = hold_q - 16'd1;
      end
      FAB_OWN: begin
        if (hold_q == '0 && hps_req) state_d = HPS_OWN;
        else if (!fab_req)           state_d = IDLE;
        else if (hold_q != '0)       hold_d  = hold_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase
    // Entry into an ownership state reloads the hold time and records the owner
    if (state_d == HPS_OWN && state_q != HPS_OWN) begin
      hold_d     = HOLD_LOAD;
      last_fab_d = 1'b0;
    end
    if (state_d == FAB_OWN && state_q != FAB_OWN) begin
      hold_d     = HOLD_LOAD;
      last_fab_d = 1'b1;
    end
  end

  // Free-running heartbeat, toggles once per HB_DIV cycles
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      hb_cnt_q <= '0;
      hb_q     <= 1'b0;
    end else if (hb_cnt_q == HB_LAST) begin
      hb_cnt_q <= '0;
      hb_q     <= ~hb_q;
    end else begin
      hb_cnt_q <= hb_cnt_q + 26'd1;
    end
  end

  // LED source selection for the current owner
  always_comb begin
    leds_d = {7'b0, hb_q};
    case (state_q)
      HPS_OWN: leds_d = hps_pattern;
      FAB_OWN: leds_d = fab_pattern;
      default: leds_d = {7'b0, hb_q};
    endcase
  end

  // Registered LED drive
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) leds_q <= '0;
    else                leds_q <= leds_d;
  end

  assign hps_gnt = (state_q == HPS_OWN);
  assign fab_gnt = (state_q == FAB_OWN);
  assign pending = (hps_gnt & fab_req) | (fab_gnt & hps_req);
  assign leds    = leds_q;
  assign status  = {fab_gnt, hps_gnt, pending, hb_q};

endmodule

// File: tb/tb_led_arbiter.sv
// Directed bench for led_arbiter with HOLD_CYCLES=4 and HB_DIV=8.
module tb_led_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hps_req, fab_req;
  logic [7:0] hps_pattern, fab_pattern;
  logic       hps_gnt, fab_gnt;
  logic [7:0] leds;
  logic [3:0] status;

  int tests = 0;
  int fails = 0;
  int edges;          // rising edges since the last reset release
  logic [7:0] e_leds;

  led_arbiter #(.HOLD_CYCLES(4), .HB_DIV(8)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .hps_req       (hps_req),
    .hps_pattern   (hps_pattern),
    .fab_req       (fab_req),
    .fab_pattern   (fab_pattern),
    .hps_gnt       (hps_gnt),
    .fab_gnt       (fab_gnt),
    .leds          (leds),
    .status        (status)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  // Expected heartbeat: toggles every 8 edges after reset release
  function automatic logic hb_at(input int n);
    return ((n / 8) % 2) == 1;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle invariants
  always @(negedge clk) begin
    check("onehot_gnt", {7'b0, hps_gnt & fab_gnt}, 8'h00);
    check("status_gnt", {6'b0, status[3:2]}, {6'b0, fab_gnt, hps_gnt});
    check("status_hb", {7'b0, status[0]}, {7'b0, rst_n ? hb_at(edges) : 1'b0});
  end

  initial begin
    rst_n = 1'b0; hps_req = 1'b0; fab_req = 1'b0;
    hps_pattern = 8'hA5; fab_pattern = 8'h3C;
    #3;
    check("rst_hps_gnt", {7'b0, hps_gnt}, 8'h00);
    check("rst_leds", leds, 8'h00);
    check("rst_status", {4'b0, status}, 8'h00);
    #19 rst_n = 1'b1;                          // t=22, between edges

    // Single HPS request
    hps_req = 1'b1;
    tick();
    check("single_hps_gnt", {6'b0, fab_gnt, hps_gnt}, 8'h01);
    tick();
    check("single_leds", leds, 8'hA5);
    check("single_pending", {7'b0, status[1]}, 8'h00);
    hps_req = 1'b0;
    tick();
    check("release_idle", {6'b0, fab_gnt, hps_gnt}, 8'h00);
    e_leds = {7'b0, hb_at(edges)};
    tick();
    check("release_leds_hb", leds, e_leds);

    // Heartbeat while idle: leds follow hb with one cycle of latency
    for (int i = 0; i < 20; i++) begin
      e_leds = {7'b0, hb_at(edges)};
      tick();
      check("hb_leds", leds, e_leds);
    end

    // Tie immediately after reset: HPS wins; early release goes via IDLE
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    hps_req = 1'b1; fab_req = 1'b1;
    tick();
    check("tie_hps_first", {6'b0, fab_gnt, hps_gnt}, 8'h01);
    check("tie_pending", {7'b0, status[1]}, 8'h01);
    hps_req = 1'b0;
    tick();
    check("tie_via_idle", {6'b0, fab_gnt, hps_gnt}, 8'h00);
    tick();
    check("tie_fab_gnt", {6'b0, fab_gnt, hps_gnt}, 8'h02);
    tick();
    check("tie_fab_leds", leds, 8'h3C);

    // Preemption: FAB releases, HPS granted, FAB asks at grant+1
    fab_req = 1'b0;
    tick();
    check("pre_idle", {6'b0, fab_gnt, hps_gnt}, 8'h00);
    hps_req = 1'b1;
    tick();
    check("pre_hps_gnt", {6'b0, fab_gnt, hps_gnt}, 8'h01);
    fab_req = 1'b1;
    #1 check("pre_pending", {7'b0, status[1]}, 8'h01);
    for (int k = 1; k < 4; k++) begin
      tick();
      check("pre_hold_hps", {6'b0, fab_gnt, hps_gnt}, 8'h01);
    end
    tick();
    check("pre_fab_at_hold", {6'b0, fab_gnt, hps_gnt}, 8'h02);
    tick();
    check("pre_fab_leds", leds, 8'h3C);
    tick();
    tick();
    check("pre_fab_still", {6'b0, fab_gnt, hps_gnt}, 8'h02);
    tick();
    check("pre_hps_regrant", {6'b0, fab_gnt, hps_gnt}, 8'h01);
    // HPS drops its request exactly when its hold expires: preemption wins
    tick(); tick(); tick();
    check("drop_hps_hold", {6'b0, fab_gnt, hps_gnt}, 8'h01);
    hps_req = 1'b0;
    tick();
    check("drop_switch_fab", {6'b0, fab_gnt, hps_gnt}, 8'h02);
    tick();
    check("drop_fab_leds", leds, 8'h3C);

    // Asynchronous reset while FAB owns
    #2 rst_n = 1'b0;
    #1;
    check("async_fab_gnt", {7'b0, fab_gnt}, 8'h00);
    check("async_leds", leds, 8'h00);
    check("async_status", {4'b0, status}, 8'h00);
    #1 rst_n = 1'b1;
    tick();
    check("post_rst_fab", {6'b0, fab_gnt, hps_gnt}, 8'h02);
    fab_req = 1'b0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
